// File: rtl/ks_pkg.sv
// rtl/ks_pkg.sv - shared types and the prefix-level operator for the Kogge-Stone pipe
package ks_pkg;

   localparam int KS_WIDTH     = 32;
   localparam int KS_LEVELS    = 5;
   localparam int KS_SLOT_BITS = 3 * KS_WIDTH + 1;

   typedef struct packed {
      logic [KS_WIDTH-1:0] g;
      logic [KS_WIDTH-1:0] p;
      logic [KS_WIDTH-1:0] p_orig;
      logic                c0;
   } ks_slot_t;

   // Bits below the span see zeros from the shift, and the all-ones low mask
   // keeps them passing through unchanged.
   function automatic ks_slot_t ks_level(input ks_slot_t s, input int unsigned d);
      ks_slot_t            r;
      logic [KS_WIDTH-1:0] lo_mask;
      lo_mask = (KS_WIDTH'(1) << d) - KS_WIDTH'(1);
      r       = s;
      r.g     = s.g | (s.p & (s.g << d));
      r.p     = s.p & ((s.p << d) | lo_mask);
      return r;
   endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// rtl/ks_prefix_level.sv - one registered Kogge-Stone prefix level of span D
module ks_prefix_level
   import ks_pkg::*;
#(
   parameter int unsigned D = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    up_valid,
   input  logic [KS_SLOT_BITS-1:0] up_slot,
   input  logic                    down_ready,
   output logic                    valid,
   output logic [KS_SLOT_BITS-1:0] slot
);

   ks_slot_t slot_q;
   logic     load;

   assign load = !valid | down_ready;
   assign slot = slot_q;

   // Data only moves on real transfers, so a bubble never disturbs held contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid  <= 1'b0;
         slot_q <= '0;
      end else if (load) begin
         valid <= up_valid;
         if (up_valid) begin
            slot_q <= ks_level(ks_slot_t'(up_slot), D);
         end
      end
   end

endmodule

// File: rtl/ks_prefix_pipe.sv
// rtl/ks_prefix_pipe.sv - five prefix levels plus a sum stage with valid/ready flow control
module ks_prefix_pipe
   import ks_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [WIDTH-1:0]  i_pk,
   input  logic [WIDTH-1:0]  i_gk,
   input  logic              i_c0,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [WIDTH-1:0]  o_sum,
   output logic              o_cout,
   output logic              o_ovf
);

   if (WIDTH != KS_WIDTH) begin : g_bad_width
      $error("ks_prefix_pipe: WIDTH must be 32");
   end

   ks_slot_t                s0;
   ks_slot_t                s5;
   logic [KS_SLOT_BITS-1:0] slot_bus  [0:KS_LEVELS];
   logic                    valid_bus [0:KS_LEVELS];
   logic [KS_LEVELS+1:1]    rdy;

   logic                    s6_valid;
   logic [KS_WIDTH-1:0]     sum_q;
   logic                    cout_q;
   logic                    ovf_q;

   // Carry-in is folded into bit 0 so the prefix tree needs no separate c0 input.
   always_comb begin
      s0        = '0;
      s0.g      = i_gk;
      s0.g[0]   = i_gk[0] | (i_pk[0] & i_c0);
      s0.p      = i_pk;
      s0.p_orig = i_pk;
      s0.c0     = i_c0;
   end

   assign slot_bus[0]  = s0;
   assign valid_bus[0] = i_valid;

   // Ready chain built from registered valids only; i_valid never enters it.
   always_comb begin
      rdy              = '0;
      rdy[KS_LEVELS+1] = !s6_valid | i_ready;
      for (int k = KS_LEVELS; k >= 1; k--) begin
         rdy[k] = !valid_bus[k] | rdy[k+1];
      end
   end

   for (genvar k = 1; k <= KS_LEVELS; k++) begin : g_level
      ks_prefix_level #(
         .D (1 << (k - 1))
      ) u_level (
         .clk        (i_clk),
         .rst        (i_rst),
         .up_valid   (valid_bus[k-1]),
         .up_slot    (slot_bus[k-1]),
         .down_ready (rdy[k+1]),
         .valid      (valid_bus[k]),
         .slot       (slot_bus[k])
      );
   end

   assign s5 = ks_slot_t'(slot_bus[KS_LEVELS]);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s6_valid <= 1'b0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (rdy[KS_LEVELS+1]) begin
         s6_valid <= valid_bus[KS_LEVELS];
         if (valid_bus[KS_LEVELS]) begin
            sum_q  <= s5.p_orig ^ {s5.g[KS_WIDTH-2:0], s5.c0};
            cout_q <= s5.g[KS_WIDTH-1];
            ovf_q  <= s5.g[KS_WIDTH-2] ^ s5.g[KS_WIDTH-1];
         end
      end
   end

   assign o_ready = rdy[1];
   assign o_valid = s6_valid;
   assign o_sum   = sum_q;
   assign o_cout  = cout_q;
   assign o_ovf   = ovf_q;

endmodule

// File: doc/ks_prefix_pipe.md
Name: ks_prefix_pipe

Overview:
- Pipelined downstream stage of the 32-bit Kogge-Stone adder; consumes per-bit propagate/generate vectors and carry-in from the pg stage.
- Runs the five prefix levels (span 1, 2, 4, 8, 16) with one register per level, then a sum/XOR stage.
- Produces the sum, carry-out and signed overflow with a valid/ready handshake on both sides, for the FFT butterfly datapath.

Parameters:
- WIDTH, 32, operand width; fixed at 32 (5 prefix levels). Any other value is a configuration error and must be flagged at elaboration.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  asynchronous reset, active-high
- i_valid  input  1  upstream pk/gk/c0 valid
- o_ready  output  1  block can accept this cycle
- i_pk  input  32  bitwise propagate, a XOR b
- i_gk  input  32  bitwise generate, a AND b
- i_c0  input  1  carry-in
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_sum  output  32  a + b + c0 (mod 2^32)
- o_cout  output  1  carry out of bit 31
- o_ovf  output  1  signed overflow: carry into bit 31 XOR carry out

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: all stage valid bits 0, so o_valid = 0. o_sum, o_cout and o_ovf reset to 0. Data registers need no reset but must not produce X on the outputs after reset.
- Pipeline slots:
  - S1..S5 hold the prefix level outputs.
  - S6 holds the final sum.
  - Each slot holds (G, P, p_orig, c0, v).
- Level 0 (combinational, before S1): G0[i] = gk[i]; P0[i] = pk[i]; except G0[0] = gk[0] | (pk[0] & c0), which folds the carry-in into bit 0.
- Level k (k = 1..5, d = 2^(k-1)):
  - For i >= d: G[i] = G'[i] | (P'[i] & G'[i-d]) and P[i] = P'[i] & P'[i-d].
  - For i < d: pass through unchanged.
  - Result is registered into Sk.
- Sum stage into S6:
  - carry[0] = c0; carry[i] = G5[i-1] for i >= 1.
  - sum[i] = p_orig[i] XOR carry[i].
  - cout = G5[31]; ovf = G5[30] XOR G5[31].
- p_orig and c0 travel unmodified alongside G/P through S1..S5.
- Latency: exactly 6 clock edges from an accepted input (i_valid & o_ready) to o_valid, when never stalled.
- Throughput: one operation per cycle.
- Handshake, with slot 7 = downstream:
  - ready_s = !v[s] | ready_{s+1}; ready_7 = i_ready; o_ready = ready_1.
  - Slot s loads when ready_s is high. Its new v = v of the previous slot, or i_valid for S1.
  - Bubbles collapse: an empty slot loads even while later slots are stalled.
  - When ready_s is low, the slot holds its data and valid.
- Output stability: while o_valid & !i_ready, o_sum, o_cout and o_ovf are held stable.
- Combinational ready chain: o_ready depends combinationally on i_ready through the slot valid bits. There is no combinational path from i_valid to o_ready.
- Simultaneous accept and drain: when the pipe is full and i_ready = 1, a new input is accepted in the same cycle as the output drains.
- Reset mid-operation: all in-flight operations are discarded and o_valid drops immediately (asynchronous). After release, the first accepted input completes with latency 6.
- Wrap-around: arithmetic is mod 2^32; the carry is reported only on o_cout.

Decomposition:
- Shared package ks_pkg:
  - KS_WIDTH = 32 and KS_LEVELS = 5.
  - Packed struct ks_slot_t {G, P, p_orig, c0}.
  - Function ks_level(slot, d) implementing one prefix level.
- One natural sub-module, ks_prefix_level:
  - One prefix level plus its slot register and valid/ready logic, parameterised by span D.
  - Instantiated five times.
- The sum stage is inline in ks_prefix_pipe.

Test Plan:
- a = 0xFFFFFFFF, b = 0x00000001, c0 = 0 (pk = 0xFFFFFFFE, gk = 0x00000001) -> after 6 cycles o_sum = 0x00000000, o_cout = 1, o_ovf = 0.
- a = 0x7FFFFFFF, b = 0x00000000, c0 = 1 -> o_sum = 0x80000000, o_cout = 0, o_ovf = 1.
- 20 back-to-back random vectors with i_ready held high -> one result per cycle, in order, each matching a+b+c0; o_ready is never low.
- Fill the pipe with 8 vectors while i_ready = 0 -> o_ready falls after 6 are accepted; o_sum is held. Then raise i_ready -> all 6 results drain in order, one per cycle.
- Alternate i_valid 1/0 with i_ready toggling pseudo-randomly -> no drops or duplicates; a scoreboard matches all results.
- Assert i_rst for 1 cycle with 3 operations in flight -> o_valid = 0 immediately. A next input 0x12345678 + 0x11111111 with c0 = 0 yields o_sum = 0x23456789 exactly 6 cycles after acceptance.
